alu_writeback: RTL and testbench

Registered writeback stage directly downstream of the 16-bit ALU. Captures the ALU `result`/`overflow` pair with the operation code and destination register, then drives the register-file write port: one write of `result` to the destination, plus a second write of `overflow` to the fixed overflow register for multiply and divide. A valid/ready handshake lets the upstream stage stall while a two-write sequence is in flight.

---
 rtl/alu_writeback.sv | 139 +++++++++++++
 tb/tb_alu_writeback.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Registered writeback stage behind the 16-bit ALU: one result write, plus an overflow-register
// write for mul/div. Optional Z/N flags are enabled with the ALU_WB_FLAGS_EN macro.
module alu_writeback #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 4,
  parameter logic [ADDR_W-1:0] OVF_REG = ADDR_W'(4'hF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_ctrl,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_overflow,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
`ifdef ALU_WB_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_RES,
    S_WR_OVF
  } state_e;

  typedef enum logic [1:0] {
    CLS_SINGLE,
    CLS_DOUBLE,
    CLS_INVALID
  } op_cls_e;

  function automatic op_cls_e classify(input logic [2:0] ctrl);
    op_cls_e cls;
    case (ctrl)
      3'b000, 3'b001, 3'b100, 3'b101: cls = CLS_SINGLE;
      3'b010, 3'b011:                 cls = CLS_DOUBLE;
      default:                        cls = CLS_INVALID;
    endcase
    return cls;
  endfunction

  state_e              state_q, state_d;
  logic                dbl_q, dbl_d;
  logic [DATA_W-1:0]   ovf_q, ovf_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  op_cls_e             in_cls;
  logic                accept;
  logic                take;

  // Ready depends only on state and the held op class, never on in_valid.
  always_comb begin
    in_ready = 1'b1;
    if (state_q == S_WR_RES && dbl_q) in_ready = 1'b0;
  end

  assign in_cls = classify(in_ctrl);
  assign accept = in_valid && in_ready;
  assign take   = accept && (in_cls != CLS_INVALID);

  // Output registers are loaded with the values of the state being entered.
  always_comb begin
    state_d   = S_IDLE;
    dbl_d     = dbl_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (accept) begin
      dbl_d = (in_cls == CLS_DOUBLE);
      ovf_d = in_overflow;
    end

    if (state_q == S_WR_RES && dbl_q) begin
      state_d   = S_WR_OVF;
      wr_en_d   = 1'b1;
      wr_addr_d = OVF_REG;
      wr_data_d = ovf_q;
    end else if (take) begin
      state_d   = S_WR_RES;
      wr_en_d   = 1'b1;
      wr_addr_d = in_rd;
      wr_data_d = in_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dbl_q     <= 1'b0;
      ovf_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      dbl_q     <= dbl_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != S_IDLE);

`ifdef ALU_WB_FLAGS_EN
  logic flag_z_q;
  logic flag_n_q;

  // During WR_RES the data register holds the latched result being committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (state_q == S_WR_RES) begin
      flag_z_q <= (wr_data_q == '0);
      flag_n_q <= wr_data_q[DATA_W-1];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: the driver predicts register-file writes and their cycles,
// and an independent monitor checks every write strobe against that prediction.
module tb_alu_writeback;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [3:0]  in_rd;
  logic [15:0] in_result;
  logic [15:0] in_overflow;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
`ifdef ALU_WB_FLAGS_EN
  logic        flag_z;
  logic        flag_n;
`endif

  alu_writeback #(.DATA_W(16), .ADDR_W(4), .OVF_REG(4'hF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_rd      (in_rd),
    .in_result  (in_result),
    .in_overflow(in_overflow),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
`ifdef ALU_WB_FLAGS_EN
    ,
    .flag_z     (flag_z),
    .flag_n     (flag_n)
`endif
  );

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         sb[$];
  logic [15:0] rf [16];
  int          cyc = 0;
  int          last_dbl_cyc = -10;
  int          n_cmp = 0;
  int          n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Number of register-file writes an op code produces.
  function automatic int writes_for(input logic [2:0] c);
    if (c == 3'd6 || c == 3'd7) return 0;
    if (c == 3'd2 || c == 3'd3) return 2;
    return 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (busy !== wr_en) begin
        n_bad++;
        $display("FAIL busy_vs_wr_en: busy %b wr_en %b (cycle %0d)", busy, wr_en, cyc);
      end
      if (wr_en) begin
        rf[wr_addr] = wr_data;
        n_cmp++;
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          n_bad++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write due (cycle %0d)", wr_addr, wr_data, cyc);
        end else begin
          wr_t e;
          e = sb.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            n_bad++;
            $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h (cycle %0d)",
                     wr_addr, wr_data, e.addr, e.data, cyc);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        wr_t e;
        e = sb.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed_write: none, expected addr %0h data %0h (cycle %0d)", e.addr, e.data, cyc);
      end
    end
  end

  task automatic step(input logic v, input logic [2:0] c, input logic [3:0] rd,
                      input logic [15:0] r, input logic [15:0] o, output logic acc);
    int nw;
    @(negedge clk);
    in_valid    = v;
    in_ctrl     = c;
    in_rd       = rd;
    in_result   = r;
    in_overflow = o;
    chk("in_ready", in_ready, (last_dbl_cyc == cyc) ? 32'd0 : 32'd1);
    acc = v && in_ready;
    if (acc) begin
      nw = writes_for(c);
      if (nw >= 1) sb.push_back('{addr: rd, data: r, cyc: cyc + 1});
      if (nw == 2) begin
        sb.push_back('{addr: 4'hF, data: o, cyc: cyc + 2});
        last_dbl_cyc = cyc + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 4'd0, 16'h0, 16'h0, a);
  endtask

  logic        acc;
  int          tries;
  logic        have;
  logic        rv;
  logic [2:0]  rc;
  logic [3:0]  rrd;
  logic [15:0] rr, ro;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_ctrl = 3'd0; in_rd = 4'd0; in_result = 16'h0; in_overflow = 16'h0;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(1);

    // add then sub back-to-back
    step(1'b1, 3'd0, 4'd3, 16'h0007, 16'h0, acc);
    step(1'b1, 3'd1, 4'd4, 16'hFFFF, 16'h0, acc);
    idle(2);

    // mul with a follow-up held valid through the stall
    step(1'b1, 3'd2, 4'd2, 16'h5678, 16'h1234, acc);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 10) begin
      step(1'b1, 3'd0, 4'd5, 16'h00AA, 16'h0, acc);
      tries++;
    end
    chk("mul_hold_tries", tries, 2);
    idle(2);

    // div writing rd 15, overflow must win
    step(1'b1, 3'd3, 4'hF, 16'h0003, 16'h0001, acc);
    idle(3);
    chk("div_final_r15", rf[15], 16'h0001);

    // invalid ops are dropped
    step(1'b1, 3'd6, 4'd7, 16'h1111, 16'h2222, acc);
    chk("inv6_accepted", acc, 1);
    step(1'b1, 3'd7, 4'd8, 16'h3333, 16'h4444, acc);
    chk("inv6_busy", busy, 0);
    idle(1);
    chk("inv7_busy", busy, 0);
    chk("inv_ready", in_ready, 1);

`ifdef ALU_WB_FLAGS_EN
    step(1'b1, 3'd1, 4'd1, 16'h0000, 16'h0, acc);
    step(1'b1, 3'd5, 4'd2, 16'h8000, 16'h0, acc);
    step(1'b1, 3'd2, 4'd3, 16'h8001, 16'h0000, acc);
    chk("flag_z_sub", flag_z, 1);
    chk("flag_n_sub", flag_n, 0);
    idle(1);
    chk("flag_z_or", flag_z, 0);
    chk("flag_n_or", flag_n, 1);
    idle(2);
    chk("flag_z_after_ovf", flag_z, 0);
    chk("flag_n_after_ovf", flag_n, 1);
`endif

    // reset asserted during the overflow write
    step(1'b1, 3'd2, 4'd6, 16'hBEEF, 16'hCAFE, acc);
    idle(1);
    @(posedge clk);
    #1;
    chk("pre_rst_ovf_wr_en", wr_en, 1);
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("rst_async_wr_en", wr_en, 0);
    chk("rst_async_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_wr_data", wr_data, 0);
    chk("rst_rel_wr_addr", wr_addr, 0);
    chk("rst_rel_busy", busy, 0);
    idle(3);

    // randomized traffic
    have = 1'b0;
    rv = 1'b0; rc = 3'd0; rrd = 4'd0; rr = 16'h0; ro = 16'h0;
    for (int i = 0; i < 400; i++) begin
      if (!have) begin
        rv  = ($urandom_range(0, 9) < 7);
        rc  = 3'($urandom_range(0, 7));
        rrd = 4'($urandom_range(0, 15));
        rr  = 16'($urandom);
        ro  = 16'($urandom);
      end
      step(rv, rc, rrd, rr, ro, acc);
      have = rv && !acc;
    end
    idle(4);
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
